// File: rtl/ysyx_22040895_ex_mem.sv
// Execute-to-memory pipeline register with branch resolution and a registered fetch redirect.
// Define YSYX_22040895_SKID_EN to add a skid entry S and register ready_o_exmem.
module ysyx_22040895_ex_mem #(
    parameter int unsigned XLEN    = 64,
    parameter int unsigned MEMOP_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_i_exmem,
    output logic               ready_o_exmem,
    input  logic [XLEN-1:0]    pc_i_exmem,
    input  logic [XLEN-1:0]    result_i_exmem,
    input  logic               lt_i_exmem,
    input  logic               ltu_i_exmem,
    input  logic               zero_i_exmem,
    input  logic [2:0]         brtype_i_exmem,
    input  logic [XLEN-1:0]    target_i_exmem,
    input  logic [XLEN-1:0]    store_i_exmem,
    input  logic [MEMOP_W-1:0] memop_i_exmem,
    input  logic [4:0]         rd_i_exmem,
    input  logic               wen_i_exmem,
    input  logic               flush_i_exmem,
    output logic               valid_o_exmem,
    input  logic               ready_i_exmem,
    output logic [XLEN-1:0]    pc_o_exmem,
    output logic [XLEN-1:0]    result_o_exmem,
    output logic [XLEN-1:0]    store_o_exmem,
    output logic [MEMOP_W-1:0] memop_o_exmem,
    output logic [4:0]         rd_o_exmem,
    output logic               wen_o_exmem,
    output logic               redirect_o_exmem,
    output logic [XLEN-1:0]    redirect_pc_o_exmem
);

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [XLEN-1:0]    result;
        logic [XLEN-1:0]    store;
        logic [MEMOP_W-1:0] memop;
        logic [4:0]         rd;
        logic               wen;
    } beat_t;

    beat_t in_beat, m_q, m_d;
    logic  m_valid_q, m_valid_d;
    logic  accept, m_xfer, taken;
    logic  redirect_q, redirect_d;
    logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;

    assign in_beat = '{pc: pc_i_exmem, result: result_i_exmem, store: store_i_exmem,
                       memop: memop_i_exmem, rd: rd_i_exmem, wen: wen_i_exmem};

    assign accept = valid_i_exmem & ready_o_exmem;
    assign m_xfer = m_valid_q & ready_i_exmem;

`ifdef YSYX_22040895_SKID_EN
    beat_t s_q, s_d;
    logic  s_valid_q, s_valid_d;

    // Registered ready: S empty guarantees room for one more beat this cycle.
    assign ready_o_exmem = ~s_valid_q;
`else
    assign ready_o_exmem = ~m_valid_q | ready_i_exmem;
`endif

    always_comb begin
        m_valid_d = m_valid_q;
        m_d       = m_q;
`ifdef YSYX_22040895_SKID_EN
        s_valid_d = s_valid_q;
        s_d       = s_q;
        if (s_valid_q) begin
            if (m_xfer) begin
                m_d       = s_q;
                s_valid_d = accept;
                if (accept) s_d = in_beat;
            end
        end else if (!m_valid_q || m_xfer) begin
            m_valid_d = accept;
            if (accept) m_d = in_beat;
        end else if (accept) begin
            s_valid_d = 1'b1;
            s_d       = in_beat;
        end
`else
        if (!m_valid_q || m_xfer) begin
            m_valid_d = accept;
            if (accept) m_d = in_beat;
        end
`endif
        if (flush_i_exmem) begin
            m_valid_d = 1'b0;
`ifdef YSYX_22040895_SKID_EN
            s_valid_d = 1'b0;
`endif
        end
    end

    always_comb begin
        case (brtype_i_exmem)
            3'b001:  taken = zero_i_exmem;
            3'b010:  taken = ~zero_i_exmem;
            3'b011:  taken = lt_i_exmem;
            3'b100:  taken = ~lt_i_exmem;
            3'b101:  taken = ltu_i_exmem;
            3'b110:  taken = ~ltu_i_exmem;
            3'b111:  taken = 1'b1;
            default: taken = 1'b0;
        endcase
    end

    // A flushed accept must not redirect; the last redirect target is held otherwise.
    always_comb begin
        redirect_d    = accept & taken & ~flush_i_exmem;
        redirect_pc_d = redirect_d ? target_i_exmem : redirect_pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q     <= 1'b0;
            m_q           <= '0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            m_valid_q     <= m_valid_d;
            m_q           <= m_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

`ifdef YSYX_22040895_SKID_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_valid_q <= 1'b0;
            s_q       <= '0;
        end else begin
            s_valid_q <= s_valid_d;
            s_q       <= s_d;
        end
    end
`endif

    assign valid_o_exmem       = m_valid_q;
    assign pc_o_exmem          = m_q.pc;
    assign result_o_exmem      = m_q.result;
    assign store_o_exmem       = m_q.store;
    assign memop_o_exmem       = m_q.memop;
    assign rd_o_exmem          = m_q.rd;
    assign wen_o_exmem         = m_q.wen;
    assign redirect_o_exmem    = redirect_q;
    assign redirect_pc_o_exmem = redirect_pc_q;

endmodule

// File: tb/tb_ysyx_22040895_ex_mem.sv
// Scoreboard bench for ysyx_22040895_ex_mem: driver pushes expected beats/redirects,
// negedge monitor pops and compares.
module tb_ysyx_22040895_ex_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_i, ready_o, lt_i, ltu_i, zero_i, wen_i, flush_i;
    logic [63:0] pc_i, result_i, target_i, store_i;
    logic [2:0]  brtype_i;
    logic [3:0]  memop_i;
    logic [4:0]  rd_i;
    logic        valid_o, ready_i, wen_o, redirect_o;
    logic [63:0] pc_o, result_o, store_o, redirect_pc_o;
    logic [3:0]  memop_o;
    logic [4:0]  rd_o;

    always #5 clk = ~clk;

    ysyx_22040895_ex_mem #(.XLEN(64), .MEMOP_W(4)) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .valid_i_exmem       (valid_i),
        .ready_o_exmem       (ready_o),
        .pc_i_exmem          (pc_i),
        .result_i_exmem      (result_i),
        .lt_i_exmem          (lt_i),
        .ltu_i_exmem         (ltu_i),
        .zero_i_exmem        (zero_i),
        .brtype_i_exmem      (brtype_i),
        .target_i_exmem      (target_i),
        .store_i_exmem       (store_i),
        .memop_i_exmem       (memop_i),
        .rd_i_exmem          (rd_i),
        .wen_i_exmem         (wen_i),
        .flush_i_exmem       (flush_i),
        .valid_o_exmem       (valid_o),
        .ready_i_exmem       (ready_i),
        .pc_o_exmem          (pc_o),
        .result_o_exmem      (result_o),
        .store_o_exmem       (store_o),
        .memop_o_exmem       (memop_o),
        .rd_o_exmem          (rd_o),
        .wen_o_exmem         (wen_o),
        .redirect_o_exmem    (redirect_o),
        .redirect_pc_o_exmem (redirect_pc_o)
    );

    typedef logic [201:0] obs_t;
    obs_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;
    int          n_out = 0;
    logic        acc_next = 1'b0, acc_taken = 1'b0;
    logic [63:0] acc_target = '0;
    logic        exp_redir;
    logic [63:0] exp_rpc;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Expected redirect: registered one cycle after a driver-announced accept.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_redir <= 1'b0;
            exp_rpc   <= '0;
        end else begin
            exp_redir <= acc_next & acc_taken;
            if (acc_next && acc_taken) exp_rpc <= acc_target;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("redirect", {255'd0, redirect_o}, {255'd0, exp_redir});
            if (exp_redir) check("redirect_pc", {192'd0, redirect_pc_o}, {192'd0, exp_rpc});
            if (valid_o && ready_i) begin
                n_out++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL extra_beat: got result %0h expected no beat", result_o);
                end else begin
                    check("beat", {54'd0, pc_o, result_o, store_o, memop_o, rd_o, wen_o},
                          {54'd0, exp_q.pop_front()});
                end
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [63:0] pc, input logic [63:0] res, input logic [63:0] tgt,
                        input logic [63:0] st, input logic [2:0] bt, input logic lt,
                        input logic ltu, input logic zero, input logic [3:0] mo,
                        input logic [4:0] rd, input logic wen, input logic taken);
        logic done;
        done = 1'b0;
        pc_i = pc; result_i = res; target_i = tgt; store_i = st; brtype_i = bt;
        lt_i = lt; ltu_i = ltu; zero_i = zero; memop_i = mo; rd_i = rd; wen_i = wen;
        valid_i = 1'b1;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            #1;
            if (ready_o) begin
                acc_next   = 1'b1;
                acc_taken  = taken;
                acc_target = tgt;
                exp_q.push_back({pc, res, st, mo, rd, wen});
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            acc_next = 1'b0;
        end
        valid_i = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got ready_o=0 for 50 cycles expected accept");
        end
    endtask

    task automatic simple(input logic [63:0] res);
        send(64'h8000_0000 + res, res, 64'd0, ~res, 3'd0, 1'b0, 1'b0, 1'b0,
             res[3:0], res[4:0], 1'b1, 1'b0);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; flush_i = 1'b0; ready_i = 1'b1;
        pc_i = '0; result_i = '0; target_i = '0; store_i = '0; brtype_i = '0;
        lt_i = 1'b0; ltu_i = 1'b0; zero_i = 1'b0; memop_i = '0; rd_i = '0; wen_i = 1'b0;
        #12;
        check("rst_valid", {255'd0, valid_o}, 256'd0);
        check("rst_redirect", {255'd0, redirect_o}, 256'd0);
        check("rst_ready", {255'd0, ready_o}, 256'd1);
        check("rst_data", {54'd0, pc_o, result_o, store_o, memop_o, rd_o, wen_o}, 256'd0);
        check("rst_redirect_pc", {192'd0, redirect_pc_o}, 256'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(1);

        // Back-to-back stream, one beat per cycle.
        for (int i = 1; i <= 4; i++) simple(64'(i));
        check("stream_valid", {255'd0, valid_o}, 256'd1);
        check("stream_last", {192'd0, result_o}, 256'd4);
        idle(2);

        // Downstream stall for three cycles mid-stream.
        ready_i = 1'b0;
        fork
            begin
                simple(64'h11);
                simple(64'h12);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                check("stall_hold", {192'd0, result_o}, 256'h11);
                check("stall_valid", {255'd0, valid_o}, 256'd1);
                check("stall_ready", {255'd0, ready_o}, 256'd0);
                ready_i = 1'b1;
            end
        join
        simple(64'h13);
        simple(64'h14);
        idle(3);

        // Branch resolution: hand-computed taken values.
        send(64'h100, 64'h1, 64'h8000_0040, 64'h0, 3'b011, 1'b1, 1'b0, 1'b0, 4'h0, 5'd1, 1'b0, 1'b1);
        send(64'h104, 64'h2, 64'h8000_0050, 64'h0, 3'b011, 1'b0, 1'b0, 1'b0, 4'h0, 5'd2, 1'b0, 1'b0);
        send(64'h108, 64'h3, 64'h8000_0060, 64'h0, 3'b110, 1'b0, 1'b0, 1'b0, 4'h0, 5'd3, 1'b0, 1'b1);
        send(64'h10c, 64'h4, 64'h8000_0064, 64'h0, 3'b010, 1'b0, 1'b0, 1'b1, 4'h0, 5'd4, 1'b0, 1'b0);
        send(64'h110, 64'h5, 64'h8000_0070, 64'h0, 3'b111, 1'b0, 1'b0, 1'b0, 4'h0, 5'd1, 1'b1, 1'b1);
        send(64'h114, 64'h6, 64'h8000_0074, 64'h0, 3'b001, 1'b1, 1'b1, 1'b0, 4'h0, 5'd2, 1'b0, 1'b0);
        send(64'h118, 64'h7, 64'h8000_0080, 64'h0, 3'b101, 1'b0, 1'b1, 1'b0, 4'h0, 5'd3, 1'b0, 1'b1);
        send(64'h11c, 64'h8, 64'h8000_0084, 64'h0, 3'b100, 1'b1, 1'b0, 1'b0, 4'h0, 5'd4, 1'b0, 1'b0);
        send(64'h120, 64'h9, 64'h8000_0088, 64'h0, 3'b000, 1'b1, 1'b1, 1'b1, 4'h0, 5'd5, 1'b0, 1'b0);
        idle(3);

        // Flush with held beats and a taken branch presented the same cycle.
        ready_i = 1'b0;
        simple(64'h21);
`ifdef YSYX_22040895_SKID_EN
        simple(64'h22);
`endif
        pc_i = 64'h200; target_i = 64'h8000_0090; brtype_i = 3'b111;
        valid_i = 1'b1; flush_i = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        valid_i = 1'b0; flush_i = 1'b0;
        check("flush_valid", {255'd0, valid_o}, 256'd0);
        ready_i = 1'b1;
        idle(2);
        check("flush_idle", {255'd0, valid_o}, 256'd0);

        // Redirect registered before a flush still pulses.
        send(64'h300, 64'h31, 64'h8000_00a0, 64'h0, 3'b111, 1'b0, 1'b0, 1'b0, 4'h0, 5'd1, 1'b1, 1'b1);
        flush_i = 1'b1;
        @(posedge clk); #1;
        exp_q.delete();
        flush_i = 1'b0;
        idle(2);

        // Asynchronous reset while a beat is held.
        ready_i = 1'b0;
        simple(64'h41);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {255'd0, valid_o}, 256'd0);
        check("arst_data", {54'd0, pc_o, result_o, store_o, memop_o, rd_o, wen_o}, 256'd0);
        check("arst_redirect", {255'd0, redirect_o}, 256'd0);
        check("arst_ready", {255'd0, ready_o}, 256'd1);
        exp_q.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        n_out = 0;
        ready_i = 1'b1;
        simple(64'h42);
        idle(3);
        check("post_reset_beats", 256'(n_out), 256'd1);
        check("scoreboard_empty", 256'(exp_q.size()), 256'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ysyx_22040895_ex_mem.md
# ysyx_22040895_ex_mem

Execute-to-memory pipeline register. It sits directly downstream of the 64-bit ALU and captures the ALU result, the ALU flags and the instruction's memory/writeback control under a valid/ready handshake. It resolves conditional branches from the ALU flags `lt`/`ltu`/`zero` and issues a registered one-cycle redirect to the fetch stage. It also supports a stall-free skid entry, so a memory-stage back-pressure event costs no bubble.

## Interface
Parameters:
- `XLEN`, default 64: datapath width, matching the ALU `RegBus`.
- `MEMOP_W`, default 4: width of the memory-op control code.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `valid_i_exmem`  in  1  execute beat valid.
- `ready_o_exmem`  out  1  stage can accept a beat.
- `pc_i_exmem`  in  XLEN  instruction PC.
- `result_i_exmem`  in  XLEN  ALU result.
- `lt_i_exmem`, `ltu_i_exmem`, `zero_i_exmem`  in  1 each  ALU flags.
- `brtype_i_exmem`  in  3  branch kind:
  - 000 none, 001 beq, 010 bne, 011 blt, 100 bge, 101 bltu, 110 bgeu, 111 unconditional jump.
- `target_i_exmem`  in  XLEN  branch/jump target.
- `store_i_exmem`  in  XLEN  store data (rs2).
- `memop_i_exmem`  in  MEMOP_W  memory op; 0 means no access.
- `rd_i_exmem`  in  5  destination register.
- `wen_i_exmem`  in  1  register write enable.
- `flush_i_exmem`  in  1  kill all held and incoming beats.
- `valid_o_exmem`  out  1  memory-stage beat valid.
- `ready_i_exmem`  in  1  memory stage accepts.
- `pc_o_exmem`, `result_o_exmem`, `store_o_exmem`  out  XLEN  registered copies of the inputs.
- `memop_o_exmem`  out  MEMOP_W  registered memory op.
- `rd_o_exmem`  out  5  registered destination register.
- `wen_o_exmem`  out  1  registered write enable.
- `redirect_o_exmem`  out  1  one-cycle pulse: branch taken.
- `redirect_pc_o_exmem`  out  XLEN  PC for the redirect.

## Operation
Handshakes:
- Input accept: `valid_i_exmem & ready_o_exmem` at the rising edge.
- Output transfer: `valid_o_exmem & ready_i_exmem`.
- Beats leave in arrival order and are never duplicated or dropped, except by flush.

Storage:
- Main entry M drives the `*_o_exmem` outputs.
- Skid entry S exists only when `YSYX_22040895_SKID_EN` is defined.
- Accept when M is empty, or M transfers this cycle with S empty: the beat loads M.
- Accept while M is held (valid, not transferring): the beat loads S.
- M transfers and S is full: S moves to M, and a simultaneous accept loads S.

Branch resolution, applied to the accepted beat:
- Taken is computed as follows: beq=`zero`, bne=`~zero`, blt=`lt`, bge=`~lt`, bltu=`ltu`, bgeu=`~ltu`, jump=1, none=0.
- If taken, the next cycle has `redirect_o_exmem`=1 and `redirect_pc_o_exmem`=target. Otherwise `redirect_o_exmem`=0.
- Redirect is independent of downstream back-pressure. Branch beats still enter M/S for PC/link writeback.
- Flushing younger upstream instructions is the fetch/decode stages' job on redirect.

Flush:
- Clears M and S valid bits next edge.
- An accept in the same cycle is dropped and produces no redirect.
- A redirect already registered last cycle still pulses; the flush does not retract it.

Reset:
- `valid_o_exmem`=0, `redirect_o_exmem`=0.
- All data/control outputs are 0, including `memop`=0 and `wen`=0.
- `redirect_pc_o_exmem`=0; S empty.
- `ready_o_exmem` reads 1, but no beat is accepted while `rst_n`=0.
- Reset asserted mid-transfer discards all beats immediately, with no redirect.

## Timing
- Latency: 1 cycle from accept to `valid_o_exmem`.
- Redirect: 1 cycle after accept, lasting exactly 1 cycle per taken beat.
- `ready_o_exmem` with SKID_EN:
  - Registered; equals "S empty".
  - Falls the cycle after a beat lands in S.
  - Rises the cycle after S drains.
- `ready_o_exmem` without SKID_EN: combinational, `~valid_o_exmem | ready_i_exmem`.
- Throughput: 1 beat/cycle while `ready_i_exmem`=1.
- Outputs stay stable while `valid_o_exmem & ~ready_i_exmem`.

## Configuration
- `YSYX_22040895_SKID_EN` defined:
  - Two-entry buffer (M+S); `ready_o_exmem` has no combinational path from `ready_i_exmem`.
- Undefined:
  - Single entry M; ready is derived combinationally from `ready_i_exmem`.
  - Functional ordering, redirect and flush behaviour are identical.

## Test plan
- Reset release, then 4 back-to-back beats with results 0x1..0x4 and `ready_i`=1 -> `valid_o` high from cycle 1, results 0x1..0x4 in order, no bubbles.
- `ready_i`=0 for 3 cycles during streaming, with SKID_EN -> M holds 0x1, S holds 0x2, `ready_o` drops one cycle later. On `ready_i`=1, outputs are 0x1 then 0x2 with no loss or duplicate.
- blt beat with `lt`=1 and target 0x8000_0040 -> `redirect_o`=1 for exactly one cycle with pc 0x8000_0040. The same beat with `lt`=0 -> no redirect.
- bgeu with `ltu`=0, and bne with `zero`=1 -> taken and not-taken respectively. Jump (111) -> always taken.
- `flush_i`=1 while M and S are full and a taken branch is presented -> `valid_o`=0 next cycle, no redirect, branch dropped.
- `rst_n` pulled low while `valid_o`=1 and `ready_i`=0 -> outputs are 0 immediately. After release, the first accepted beat is the only output.
